// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared states, segment codes and divider constants for the MM:SS display.
package seg_display_pkg;
  typedef enum logic [2:0] {IDLE, DIV, SPLIT, BCD_M, BCD_S, LOAD} state_t;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] DIVISOR = 7'd60;
  localparam logic [15:0] MAX_MIN = 16'd99;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational digit to active-low gfedcba segment code; 10..15 show blank.
module bcd_to_7seg
  import seg_display_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    case (d)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_display_mmss.sv
// seg_display_mmss: seconds -> MM:SS on four active-low 7-segment digits via sequential divide-by-60.
// Optional SEG_ZERO_BLINK_EN blinks 00:00 once a nonzero value has been shown.
module seg_display_mmss
  import seg_display_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] segundos,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        busy,
  output logic        ovf
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  if (HALF < 1) begin : g_bad_cfg
    $error("seg_display_mmss: CLK_HZ must be at least 2*BLINK_HZ");
  end
  state_t state;
  logic [15:0] last, work, quo;
  logic [6:0] rem, r_sh;
  logic [3:0] cnt, mt, st;
  logic clamp, ge;
  logic [6:0] h0, h1, h2, h3, s0, s1, s2, s3;
  assign r_sh = {rem[5:0], work[15]};
  assign ge = r_sh >= DIVISOR;
  bcd_to_7seg u_s0 (.d(rem[3:0]), .seg(s0));
  bcd_to_7seg u_s1 (.d(st), .seg(s1));
  bcd_to_7seg u_s2 (.d(quo[3:0]), .seg(s2));
  bcd_to_7seg u_s3 (.d(mt), .seg(s3));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= '0;
      work <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
      mt <= '0;
      st <= '0;
      clamp <= 1'b0;
      busy <= 1'b0;
      ovf <= 1'b0;
      h0 <= SEG_0;
      h1 <= SEG_0;
      h2 <= SEG_0;
      h3 <= SEG_0;
    end else begin
      case (state)
        IDLE: if (segundos != last) begin
          last <= segundos;
          work <= segundos;
          quo <= '0;
          rem <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          rem <= ge ? r_sh - DIVISOR : r_sh;
          quo <= {quo[14:0], ge};
          work <= {work[14:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= SPLIT;
        end
        SPLIT: begin
          clamp <= quo > MAX_MIN;
          if (quo > MAX_MIN) begin
            quo <= MAX_MIN;
            rem <= 7'd59;
          end
          mt <= '0;
          st <= '0;
          state <= BCD_M;
        end
        // leave on the final subtraction so the loop never spends an extra compare cycle
        BCD_M: begin
          if (quo >= 16'd10) begin
            quo <= quo - 16'd10;
            mt <= mt + 4'd1;
          end
          if (quo < 16'd20) state <= BCD_S;
        end
        BCD_S: begin
          if (rem >= 7'd10) begin
            rem <= rem - 7'd10;
            st <= st + 4'd1;
          end
          if (rem < 7'd20) state <= LOAD;
        end
        LOAD: begin
          h0 <= s0;
          h1 <= s1;
          h2 <= s2;
          h3 <= s3;
          ovf <= clamp;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SEG_ZERO_BLINK_EN
  logic arm, zero, phase;
  logic [31:0] div;
  logic nz, blank;
  assign nz = |{quo[3:0], mt, rem[3:0], st};
  assign blank = arm && zero && phase;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm <= 1'b0;
      zero <= 1'b1;
      phase <= 1'b0;
      div <= '0;
    end else if (state == LOAD) begin
      div <= '0;
      phase <= 1'b0;
      zero <= !nz;
      if (nz) arm <= !clamp;
    end else if (div == 32'(HALF - 1)) begin
      div <= '0;
      phase <= !phase;
    end else begin
      div <= div + 32'd1;
    end
  end
  assign hex0 = blank ? SEG_BLANK : h0;
  assign hex1 = blank ? SEG_BLANK : h1;
  assign hex2 = blank ? SEG_BLANK : h2;
  assign hex3 = blank ? SEG_BLANK : h3;
`else
  assign hex0 = h0;
  assign hex1 = h1;
  assign hex2 = h2;
  assign hex3 = h3;
`endif
endmodule

// File: tb/tb_seg_display_mmss.sv
// tb_seg_display_mmss: directed checks of seg_display_mmss with hand-computed digit codes.
module tb_seg_display_mmss;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] segundos = '0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic busy, ovf;
  int n_cmp = 0, n_bad = 0;
  int n, tot;
  seg_display_mmss #(.CLK_HZ(40), .BLINK_HZ(2)) dut (
    .clk(clk), .rst(rst), .segundos(segundos),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_hex(input string tag, input logic [27:0] exp, input logic eovf);
    chk({tag, " digits"}, {4'h0, hex3, hex2, hex1, hex0}, {4'h0, exp});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic convert(input string tag, input logic [15:0] v, input logic [27:0] exp, input logic eovf);
    segundos = v;
    @(negedge clk);
    chk({tag, " busy rise"}, {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk({tag, " latency ok"}, {31'd0, n <= 33}, 32'd1);
    chk_hex(tag, exp, eovf);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_hex("reset", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("idle at zero", {31'd0, busy}, 32'd0);
    convert("125", 16'd125, {7'h40, 7'h24, 7'h40, 7'h12}, 1'b0);
    convert("5999", 16'd5999, {7'h10, 7'h10, 7'h12, 7'h10}, 1'b0);
    convert("6000", 16'd6000, {7'h10, 7'h10, 7'h12, 7'h10}, 1'b1);
    convert("65535", 16'd65535, {7'h10, 7'h10, 7'h12, 7'h10}, 1'b1);
    convert("zero", 16'd0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
    // retarget mid-conversion: 59 must still land, then 60 follows
    segundos = 16'd59;
    tot = 0;
    n = 0;
    while (n < 3 && tot < 40) begin
      @(negedge clk);
      tot++;
      if (busy) n++;
    end
    segundos = 16'd60;
    wait_idle(n);
    tot += n;
    chk_hex("59 first", {7'h40, 7'h40, 7'h12, 7'h10}, 1'b0);
    @(negedge clk);
    tot++;
    chk("60 restart", {31'd0, busy}, 32'd1);
    wait_idle(n);
    tot += n;
    chk_hex("60 after", {7'h40, 7'h79, 7'h40, 7'h40}, 1'b0);
    chk("retarget time ok", {31'd0, tot <= 67}, 32'd1);
    // asynchronous reset in the middle of a conversion
    segundos = 16'd3723;
    repeat (6) @(negedge clk);
    chk("3723 in flight", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_hex("async reset", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("3723 restart", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("3723 latency ok", {31'd0, n <= 33}, 32'd1);
    chk_hex("3723", {7'h02, 7'h24, 7'h40, 7'h30}, 1'b0);
`ifdef SEG_ZERO_BLINK_EN
    rst = 1'b1;
    segundos = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hex0 !== 7'h40) n++;
    end
    chk("no blink from reset", n, 32'd0);
    convert("blink 3", 16'd3, {7'h40, 7'h40, 7'h40, 7'h30}, 1'b0);
    convert("blink 0", 16'd0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
    repeat (5) @(negedge clk);
    chk("blink on", {25'd0, hex3}, 32'h40);
    repeat (10) @(negedge clk);
    chk("blink off", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, {4{7'h7F}}});
    repeat (10) @(negedge clk);
    chk("blink back", {25'd0, hex0}, 32'h40);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
